riscv_fetch_unit: RTL and testbench
===================================

# riscv_fetch_unit

Instruction fetch stage placed directly upstream of the decoder and control unit. It owns the program counter, issues pipelined requests to instruction memory over a req/gnt/rvalid handshake, and buffers responses in a small prefetch FIFO. It presents each fetched word with its PC to the decoder over a valid/ready handshake, and accepts redirects from branch, JAL and JALR resolution.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries and maximum in-flight requests. Power of two, legal range 2..8.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch byte address. Always 4-aligned.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid. Responses arrive in order, at least 1 cycle after their gnt.
- imem_rdata_i  in  32  response instruction word.
- redirect_i  in  1  flush and refetch from redirect_pc_i.
- redirect_pc_i  in  32  new fetch target.
- instr_valid_o  out  1  instr_o and instr_pc_o are valid.
- instr_o  out  32  instruction to the decoder.
- instr_pc_o  out  32  PC of instr_o.
- instr_ready_i  in  1  decoder consumes the word this cycle.
- misalign_o  out  1  misaligned-redirect flag. See Configuration.

## Operation
- State:
  - fa: fetch address.
  - rpc: PC of the next accepted response.
  - outstanding: granted requests without a response yet.
  - discard: responses still to drop.
  - FIFO of {instr, pc}.
- pop = instr_valid_o & instr_ready_i.
- credit_ok = (outstanding + fifo_count - pop) < FIFO_DEPTH.
- imem_req_o = credit_ok & ~redirect_i. imem_addr_o = fa.
- The address is held stable while req is high without gnt. The request may be withdrawn only when credits drop, or on redirect.
- On gnt: fa += 4 (wraps modulo 2^32) and outstanding increments.
- On rvalid with discard == 0:
  - Push {imem_rdata_i, rpc}; rpc += 4; outstanding decrements.
  - A push cannot overflow because of the credit rule.
- On rvalid with discard > 0:
  - Drop the word; discard and outstanding both decrement.
- rvalid while outstanding == 0 is ignored. This is a protocol violation and must not corrupt state.
- Redirect (redirect_i high), at the clock edge:
  - fa and rpc take {redirect_pc_i[31:2], 2'b00}.
  - The FIFO is emptied.
  - discard takes outstanding minus any response arriving in the same cycle.
  - A pop in the same cycle is overridden; the flush wins.
- FIFO push and pop in the same cycle are both performed; the count is unchanged.
- instr_valid_o = FIFO not empty. instr_o and instr_pc_o come from the FIFO head.
- Outputs stay stable while instr_valid_o & ~instr_ready_i.

## Timing
- Reset values: imem_addr_o = RESET_PC, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, misalign_o = 0. All counters are 0 and the FIFO is empty.
- imem_req_o is 1 in the first cycle after reset deassertion.
- Reset asserted mid-operation clears all state asynchronously. Stale rvalid after reset is ignored because outstanding == 0.
- Latency:
  - gnt at cycle t, rvalid at t+1, instr_valid_o at t+2.
  - Minimum redirect-to-valid is 3 cycles: edge, req+gnt, rvalid, FIFO.
- Throughput: 1 instruction per cycle sustained with a 1-cycle memory, FIFO_DEPTH=2, and ready held high.
- No combinational path from imem_rvalid_i or imem_rdata_i to the instr_* outputs.
- imem_req_o depends combinationally on instr_ready_i and redirect_i.

## Configuration
- RISCV_FETCH_MISALIGN_EN defined:
  - A redirect with redirect_pc_i[1:0] != 0 still flushes and sets discard.
  - It then sets misalign_o and stops issuing requests. instr_valid_o stays 0.
  - misalign_o is sticky until an aligned redirect or reset.
- RISCV_FETCH_MISALIGN_EN undefined:
  - redirect_pc_i[1:0] is ignored and treated as 00.
  - misalign_o is tied to 0.

## Test plan
- **Reset, 1-cycle memory, gnt always 1, ready always 1:** imem_addr_o sequences 0x0, 0x4, 0x8…. From cycle 2 the bench sees instr_valid_o continuously, with instr_pc_o = 0x0, 0x4, ….
- **Decoder backpressure:** ready=0 for 5 cycles after the first word. After at most FIFO_DEPTH grants, imem_req_o drops to 0. instr_o and instr_pc_o hold 0x0. Releasing ready resumes the sequence in order with no loss or duplication.
- **Redirect with 2 in flight to 0x100:** the old responses are dropped. The next delivered word has instr_pc_o = 0x100 and carries the data returned for address 0x100.
- **gnt withheld 3 cycles at 0x8:** imem_addr_o stays 0x8 with req high throughout, and no pc skips occur.
- **Redirect coinciding with pop and rvalid:** the FIFO ends empty and discard equals outstanding−1. The first valid output afterwards has instr_pc_o = redirect target.
- **With RISCV_FETCH_MISALIGN_EN, redirect to 0x102:** misalign_o=1 and no further requests. A redirect to 0x200 clears the flag, and fetching resumes at 0x200.

Source files
------------

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited pipelined imem requests and buffers responses in a prefetch FIFO.
// Optional feature macro RISCV_FETCH_MISALIGN_EN: a misaligned redirect sets a sticky misalign_o and halts fetching.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misalign_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fa_q, fa_d, rpc_q, rpc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic          mis_q, mis_d;
  logic [31:0]   instr_mem_q [FIFO_DEPTH];
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];

  logic          pop, resp, push, gnt, credit_ok, mis_target;
  logic [31:0]   target;
  logic [CW:0]   occupancy;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign pop       = (cnt_q != '0) & instr_ready_i;
  assign resp      = imem_rvalid_i & (out_q != '0);
  assign push      = resp & (disc_q == '0);
  assign occupancy = {1'b0, out_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
  assign credit_ok = occupancy < DEPTH_W;
  assign imem_req_o = credit_ok & ~redirect_i & ~mis_q;
  assign gnt        = imem_req_o & imem_gnt_i;
  assign target     = {redirect_pc_i[31:2], 2'b00};

`ifdef RISCV_FETCH_MISALIGN_EN
  assign mis_target = redirect_pc_i[1:0] != 2'b00;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign mis_target    = 1'b0;
`endif

  // NOTE: every next-state signal gets its hold value first, so this block can never infer a latch.
  always_comb begin
    fa_d   = fa_q;
    rpc_d  = rpc_q;
    disc_d = disc_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    mis_d  = mis_q;
    out_d  = out_q + CW'(gnt) - CW'(resp);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (gnt) fa_d = fa_q + 32'd4;
    if (push) begin
      rpc_d = rpc_q + 32'd4;
      wr_d  = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    if (resp && !push) disc_d = disc_q - CW'(1);
    // Flush wins over any same-cycle push or pop; in-flight words become discards.
    if (redirect_i) begin
      fa_d   = target;
      rpc_d  = target;
      cnt_d  = '0;
      rd_d   = '0;
      wr_d   = '0;
      disc_d = out_q - CW'(resp);
      mis_d  = mis_target;
    end
  end

  // NOTE: state registers use non-blocking assignments only; all decisions live in the comb block above.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fa_q   <= RESET_PC;
      rpc_q  <= RESET_PC;
      out_q  <= '0;
      disc_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      mis_q  <= 1'b0;
    end else begin
      fa_q   <= fa_d;
      rpc_q  <= rpc_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      mis_q  <= mis_d;
    end
  end

  // NOTE: the FIFO storage is reset so the head reads as zero before the first push.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_q] <= imem_rdata_i;
      pc_mem_q[wr_q]    <= rpc_q;
    end
  end

  assign imem_addr_o   = fa_q;
  assign instr_valid_o = cnt_q != '0;
  assign instr_o       = instr_mem_q[rd_q];
  assign instr_pc_o    = pc_mem_q[rd_q];
  assign misalign_o    = mis_q;
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: random memory/decoder/redirect stimulus against a stream-level reference model,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_riscv_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef RISCV_FETCH_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i, redirect_i;
  logic [31:0] imem_addr_o, imem_rdata_i, redirect_pc_i, instr_o, instr_pc_o;
  logic        instr_valid_o, instr_ready_i, misalign_o;

  always #5 clk_i = ~clk_i;

  riscv_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .misalign_o(misalign_o)
  );

  int unsigned total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ {a[31:16], 16'h0} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit pct(input int unsigned p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
    else t = 32'($urandom_range(0, 1023));
    if (MIS_EN && $urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  // Stimulus knobs
  int unsigned gnt_pct, rv_pct, rdy_pct, redir_pct, lat_min, lat_max, hold_left;
  logic [31:0] hold_addr, force_tgt;
  bit          rdy_force_en, rdy_force_val, force_redir, stray, stray_now;

  // Reference model: memory requests in flight and the instruction stream the decoder must see
  typedef struct { logic [31:0] addr; int unsigned due; int unsigned epoch; } pend_t;
  pend_t       pend[$];
  int unsigned cyc = 0, epoch = 0, pop_cnt = 0, grant_cnt = 0;
  int          buffered = 0;
  logic [31:0] exp_pc = RPC, exp_fa = RPC;
  bit          exp_mis = 1'b0;
  logic [31:0] last_pop_pc, last_pop_instr;
  bit          p_hold = 1'b0, p_wait = 1'b0;
  logic [31:0] p_instr, p_pc, p_addr;

  initial begin
    pend_t r;
    int    occ;
    bit    exp_req, pop_req;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    redirect_i = 0; redirect_pc_i = 0; instr_ready_i = 0;
    forever begin
      @(posedge clk_i); #1;
      cyc++;
      stray_now = 1'b0;
      if (rst_i) begin
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        redirect_i = 0; redirect_pc_i = 0; instr_ready_i = 0;
      end else begin
        if (stray) begin
          imem_rvalid_i = 1; imem_rdata_i = $urandom; stray = 0; stray_now = 1;
        end else if (pend.size() != 0 && pend[0].due <= cyc && pct(rv_pct)) begin
          imem_rvalid_i = 1; imem_rdata_i = mem_word(pend[0].addr);
        end else begin
          imem_rvalid_i = 0; imem_rdata_i = $urandom;
        end
        instr_ready_i = rdy_force_en ? rdy_force_val : pct(rdy_pct);
        if (force_redir) begin
          redirect_i = 1; redirect_pc_i = force_tgt; force_redir = 0;
        end else if (pct(redir_pct)) begin
          redirect_i = 1; redirect_pc_i = rand_target();
        end else begin
          redirect_i = 0; redirect_pc_i = $urandom;
        end
        if (hold_left != 0 && imem_addr_o == hold_addr) begin
          imem_gnt_i = 0; hold_left--;
        end else imem_gnt_i = pct(gnt_pct);
        #1 imem_gnt_i = imem_gnt_i & imem_req_o;
      end
      @(negedge clk_i);
      if (rst_i) begin
        pend.delete(); epoch++; buffered = 0;
        exp_pc = RPC; exp_fa = RPC; exp_mis = 0; p_hold = 0; p_wait = 0;
      end else begin
        pop_req = instr_valid_o & instr_ready_i;
        occ     = int'(pend.size()) + buffered - (pop_req ? 1 : 0);
        exp_req = (occ < DEPTH) && !redirect_i && !exp_mis;
        check("valid_vs_model", instr_valid_o, 32'(buffered != 0));
        check("misalign_vs_model", misalign_o, 32'(exp_mis));
        check("req_credit", imem_req_o, 32'(exp_req));
        check("addr_aligned", imem_addr_o[1:0], 0);
        if (p_hold) begin
          check("hold_valid", instr_valid_o, 1);
          check("hold_instr", instr_o, p_instr);
          check("hold_pc", instr_pc_o, p_pc);
        end
        if (p_wait) check("addr_stable", imem_addr_o, p_addr);
        if (imem_rvalid_i && !stray_now && pend.size() != 0) begin
          r = pend.pop_front();
          if (r.epoch == epoch) buffered++;
        end
        if (imem_req_o && imem_gnt_i) begin
          check("grant_addr", imem_addr_o, exp_fa);
          pend.push_back('{imem_addr_o, cyc + $urandom_range(lat_min, lat_max), epoch});
          exp_fa += 32'd4;
          grant_cnt++;
        end
        if (pop_req && !redirect_i) begin
          check("pop_pc", instr_pc_o, exp_pc);
          check("pop_instr", instr_o, mem_word(exp_pc));
          last_pop_pc = instr_pc_o; last_pop_instr = instr_o;
          pop_cnt++; exp_pc += 32'd4; buffered--;
        end
        if (redirect_i) begin
          epoch++; buffered = 0;
          exp_pc  = {redirect_pc_i[31:2], 2'b00};
          exp_fa  = exp_pc;
          exp_mis = MIS_EN && (redirect_pc_i[1:0] != 2'b00);
        end
        p_hold  = instr_valid_o && !instr_ready_i && !redirect_i;
        p_instr = instr_o; p_pc = instr_pc_o;
        p_wait  = imem_req_o && !imem_gnt_i && !redirect_i;
        p_addr  = imem_addr_o;
      end
    end
  end

  task automatic set_steady();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100; redir_pct = 0;
    lat_min = 1; lat_max = 1; rdy_force_en = 0; rdy_force_val = 0; hold_left = 0;
  endtask

  // Leaves the caller just after reset release; the next negedge is cycle 0.
  task automatic do_reset();
    @(negedge clk_i); #1 rst_i = 1;
    repeat (2) @(negedge clk_i);
    #1 rst_i = 0;
  endtask

  task automatic wait_pop(input string name, input int unsigned from);
    int n = 0;
    while (pop_cnt == from && n < 40) begin @(negedge clk_i); #1; n++; end
    check(name, 32'(pop_cnt != from), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned g0, p0;
    int n;
    set_steady(); force_redir = 0; stray = 0; hold_addr = 0; force_tgt = 0;

    // 1-cycle memory, always granted, always ready: one word per cycle from cycle 2
    do_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      check("p1_req", imem_req_o, 1);
      check("p1_addr", imem_addr_o, RPC + 32'(4 * k));
      if (k < 2) begin
        check("p1_valid_early", instr_valid_o, 0);
        check("p1_instr_reset", instr_o, 0);
        check("p1_pc_reset", instr_pc_o, 0);
      end else begin
        check("p1_valid", instr_valid_o, 1);
        check("p1_pc", instr_pc_o, 32'(4 * (k - 2)));
        check("p1_instr", instr_o, mem_word(32'(4 * (k - 2))));
      end
    end
    // Redirect in a cycle that also pops and receives a response
    force_tgt = 32'h300; force_redir = 1;
    @(negedge clk_i);
    check("p5_coincide_valid", instr_valid_o, 1);
    check("p5_coincide_rvalid", imem_rvalid_i, 1);
    check("p5_req_low", imem_req_o, 0);
    @(negedge clk_i);
    check("p5_flushed", instr_valid_o, 0);
    check("p5_req", imem_req_o, 1);
    check("p5_addr", imem_addr_o, 32'h300);
    @(negedge clk_i);
    check("p5_valid_c2", instr_valid_o, 0);
    @(negedge clk_i);
    check("p5_valid_c3", instr_valid_o, 1);
    check("p5_pc", instr_pc_o, 32'h300);

    // Decoder backpressure
    set_steady(); rdy_force_en = 1; rdy_force_val = 0;
    do_reset();
    #0 g0 = grant_cnt;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!instr_valid_o && n < 20);
    check("p2_first_valid", instr_valid_o, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("p2_hold_valid", instr_valid_o, 1);
      check("p2_hold_pc", instr_pc_o, 32'h0);
      check("p2_hold_instr", instr_o, mem_word(32'h0));
    end
    #1;
    check("p2_req_dropped", imem_req_o, 0);
    check("p2_grants_bounded", 32'(grant_cnt - g0 <= DEPTH), 1);
    p0 = pop_cnt; rdy_force_en = 0;
    repeat (12) @(negedge clk_i);
    #1 check("p2_resume_progress", 32'(pop_cnt - p0 >= 8), 1);

    // Redirect with two requests in flight
    set_steady(); lat_min = 3; lat_max = 3;
    do_reset();
    n = 0;
    do begin @(negedge clk_i); #1; n++; end while (pend.size() < 2 && n < 20);
    check("p3_two_inflight", 32'(pend.size() >= 2), 1);
    force_tgt = 32'h100; force_redir = 1;
    @(negedge clk_i); #1 p0 = pop_cnt;
    wait_pop("p3_wait_pop", p0);
    check("p3_pc", last_pop_pc, 32'h100);
    check("p3_instr", last_pop_instr, mem_word(32'h100));

    // Grant withheld for 3 cycles at 0x8
    set_steady(); hold_addr = 32'h8; hold_left = 3;
    do_reset();
    n = 0;
    do begin @(negedge clk_i); n++; end while (imem_addr_o != 32'h8 && n < 20);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk_i);
      check("p4_addr_held", imem_addr_o, 32'h8);
      check("p4_req_held", imem_req_o, 1);
    end
    p0 = pop_cnt;
    repeat (15) @(negedge clk_i);
    #1 check("p4_progress", 32'(pop_cnt - p0 >= 8), 1);

    // Misaligned redirect
    set_steady();
    do_reset();
    repeat (6) @(negedge clk_i);
    force_tgt = 32'h102; force_redir = 1;
    @(negedge clk_i);
`ifdef RISCV_FETCH_MISALIGN_EN
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("p6_misalign_set", misalign_o, 1);
      check("p6_no_req", imem_req_o, 0);
      check("p6_no_valid", instr_valid_o, 0);
    end
    force_tgt = 32'h200; force_redir = 1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("p6_misalign_clr", misalign_o, 0);
    check("p6_req_resume", imem_req_o, 1);
    check("p6_addr_resume", imem_addr_o, 32'h200);
    #1 p0 = pop_cnt;
    wait_pop("p6_wait_pop", p0);
    check("p6_pc", last_pop_pc, 32'h200);
`else
    @(negedge clk_i);
    check("p6_misalign_tied", misalign_o, 0);
    check("p6_addr_aligned", imem_addr_o, 32'h100);
    #1 p0 = pop_cnt;
    wait_pop("p6_wait_pop", p0);
    check("p6_pc", last_pop_pc, 32'h100);
    check("p6_instr", last_pop_instr, mem_word(32'h100));
`endif

    // Random traffic with an asynchronous mid-run reset and a stray response after it
    gnt_pct = 70; rv_pct = 70; rdy_pct = 70; redir_pct = 3;
    lat_min = 1; lat_max = 4; rdy_force_en = 0; hold_left = 0;
    do_reset();
    repeat (1500) @(negedge clk_i);
    @(posedge clk_i); #3 rst_i = 1;
    #1;
    check("rst_async_valid", instr_valid_o, 0);
    check("rst_async_addr", imem_addr_o, RPC);
    check("rst_async_instr", instr_o, 0);
    check("rst_async_pc", instr_pc_o, 0);
    check("rst_async_misalign", misalign_o, 0);
    stray = 1;
    repeat (2) @(negedge clk_i);
    #1 rst_i = 0;
    p0 = pop_cnt;
    repeat (1500) @(negedge clk_i);
    #1 check("rand_progress", 32'(pop_cnt - p0 >= 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
